// File: rtl/lcg_ranged_rng_if.sv
// Capture handshake between the random-number generator and its consumer.
// Ports (per signal):
//   req       - capture request pulse ("stop button")
//   limit     - inclusive upper bound for the captured number, sampled at req
//   num       - captured random number
//   num_valid - num holds an unconsumed result
//   num_ready - consumer accepts num
//   busy      - generator is searching for an in-range value
// Modports: master = requester/consumer side, slave = generator side.
interface lcg_ranged_rng_if #(
   parameter int unsigned WIDTH = 4
);
   logic             req;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] num;
   logic             num_valid;
   logic             num_ready;
   logic             busy;

   modport master (
      output req,
      output limit,
      output num_ready,
      input  num,
      input  num_valid,
      input  busy
   );

   modport slave (
      input  req,
      input  limit,
      input  num_ready,
      output num,
      output num_valid,
      output busy
   );
endinterface

// File: rtl/lcg_ranged_rng.sv
// Free-running LCG random-number generator with a ranged capture.
// A request captures the current value if it is within [0, limit];
// otherwise the generator keeps stepping every cycle until an in-range
// value appears, which is then captured and held until the consumer takes it.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   seed_we    - load seed into the generator state this edge (any state)
//   seed       - seed value
//   run        - free-run enable in IDLE/HOLD
//   bus        - capture handshake (req/limit in, num/num_valid/busy out)
// A mod 4 must be 1 and C must be odd so the generator has full period;
// that is what bounds the search to 2^WIDTH edges.
module lcg_ranged_rng #(
   parameter int unsigned WIDTH        = 4,
   parameter int unsigned A            = 5,
   parameter int unsigned C            = 1,
   parameter int unsigned SEED_DEFAULT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_we,
   input  logic [WIDTH-1:0] seed,
   input  logic             run,
   lcg_ranged_rng_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] cur_nxt;
   logic [WIDTH-1:0] lcg_next;
   logic [WIDTH-1:0] num_q;
   logic [WIDTH-1:0] num_nxt;
   logic [WIDTH-1:0] limit_q;
   logic [WIDTH-1:0] limit_nxt;
   logic             valid_q;
   logic             valid_nxt;
   logic             busy_q;

   // LCG step; the product wraps at WIDTH bits by construction.
   assign lcg_next = WIDTH'(A) * cur + WIDTH'(C);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.req) begin
               state_nxt = (cur <= bus.limit) ? HOLD : SEARCH;
            end
         end
         SEARCH: begin
            if (cur <= limit_q) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (bus.num_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      cur_nxt   = cur;
      num_nxt   = num_q;
      limit_nxt = limit_q;
      valid_nxt = valid_q;
      case (state)
         IDLE: begin
            if (run) begin
               cur_nxt = lcg_next;
            end
            if (bus.req) begin
               limit_nxt = bus.limit;
               if (cur <= bus.limit) begin
                  num_nxt   = cur;
                  valid_nxt = 1'b1;
               end else begin
                  // A miss always advances, even with run low.
                  cur_nxt = lcg_next;
               end
            end
         end
         SEARCH: begin
            // Searching ignores run; cur is held on the accepting edge.
            if (cur <= limit_q) begin
               num_nxt   = cur;
               valid_nxt = 1'b1;
            end else begin
               cur_nxt = lcg_next;
            end
         end
         HOLD: begin
            if (run) begin
               cur_nxt = lcg_next;
            end
            if (bus.num_ready) begin
               valid_nxt = 1'b0;
            end
         end
         default: begin
            valid_nxt = 1'b0;
         end
      endcase
      // Seed load wins over any stepping but never blocks a capture of the
      // pre-load value.
      if (seed_we) begin
         cur_nxt = seed;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur     <= WIDTH'(SEED_DEFAULT);
         num_q   <= '0;
         limit_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         cur     <= cur_nxt;
         num_q   <= num_nxt;
         limit_q <= limit_nxt;
         valid_q <= valid_nxt;
         busy_q  <= (state_nxt == SEARCH);
      end
   end

   assign bus.num       = num_q;
   assign bus.num_valid = valid_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_lcg_ranged_rng.sv
// Self-checking bench for lcg_ranged_rng (WIDTH=4, A=5, C=1, SEED_DEFAULT=4).
// Directed steps for the listed scenarios followed by a randomized run,
// all checked against a behavioural model of the capture protocol.
module tb_lcg_ranged_rng;

   localparam int unsigned W    = 4;
   localparam int          MA   = 5;
   localparam int          MC   = 1;
   localparam int          MOD  = 16;
   localparam int          SEED0 = 4;

   logic         clk;
   logic         rst_n;
   logic         seed_we;
   logic [W-1:0] seed;
   logic         run;

   lcg_ranged_rng_if #(.WIDTH(W)) bus ();

   lcg_ranged_rng #(
      .WIDTH(W), .A(MA), .C(MC), .SEED_DEFAULT(SEED0)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .seed_we (seed_we),
      .seed    (seed),
      .run     (run),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: mode 0 = waiting, 1 = searching, 2 = holding a result
   int m_cur, m_num, m_valid, m_mode, m_limq;
   int seen [MOD];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".cur"},       32'(dut.cur),       32'(m_cur));
      check({tag, ".num"},       32'(bus.num),       32'(m_num));
      check({tag, ".num_valid"}, 32'(bus.num_valid), 32'(m_valid));
      check({tag, ".busy"},      32'(bus.busy),      32'(m_mode == 1));
   endtask

   // Apply the currently driven inputs for one rising edge; pulses are cleared after.
   task automatic step(input string tag);
      int nxt;
      int new_cur;
      nxt     = (MA * m_cur + MC) % MOD;
      new_cur = run ? nxt : m_cur;
      case (m_mode)
         0: if (bus.req) begin
               m_limq = int'(bus.limit);
               if (m_cur <= int'(bus.limit)) begin
                  m_num = m_cur; m_valid = 1; m_mode = 2;
               end else begin
                  new_cur = nxt; m_mode = 1;
               end
            end
         1: if (m_cur <= m_limq) begin
               m_num = m_cur; m_valid = 1; m_mode = 2; new_cur = m_cur;
            end else begin
               new_cur = nxt;
            end
         default: if (bus.num_ready) begin
               m_valid = 0; m_mode = 0;
            end
      endcase
      if (seed_we) new_cur = int'(seed);
      m_cur = new_cur;
      @(posedge clk);
      #1;
      compare_all(tag);
      bus.req       = 1'b0;
      seed_we       = 1'b0;
      bus.num_ready = 1'b0;
   endtask

   // Asynchronous reset: checked before any clock edge, released at a falling edge.
   task automatic do_reset(input string tag);
      rst_n         = 1'b0;
      bus.req       = 1'b0;
      bus.num_ready = 1'b0;
      seed_we       = 1'b0;
      run           = 1'b0;
      #1;
      m_cur = SEED0; m_num = 0; m_valid = 0; m_mode = 0; m_limq = 0;
      compare_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n         = 1'b1;
      run           = 1'b0;
      seed_we       = 1'b0;
      seed          = '0;
      bus.req       = 1'b0;
      bus.limit     = '0;
      bus.num_ready = 1'b0;
      #2;
      do_reset("rst0");

      // Three free-run steps then a full-range request hits immediately.
      run = 1'b1;
      for (int i = 0; i < 3; i++) step("run3");
      check("run3_cur", 32'(dut.cur), 32'd3);
      run = 1'b0; bus.req = 1'b1; bus.limit = 4'd15;
      step("hit15");
      check("hit15_num",   32'(bus.num),       32'd3);
      check("hit15_valid", 32'(bus.num_valid), 32'd1);
      check("hit15_busy",  32'(bus.busy),      32'd0);
      bus.num_ready = 1'b1;
      step("ack0");

      // Miss from reset: search visits 5,10,3,0 and captures 0.
      do_reset("rst1");
      bus.req = 1'b1; bus.limit = 4'd2;
      step("srch_req");
      begin
         int orbit [4] = '{5, 10, 3, 0};
         for (int i = 0; i < 4; i++) begin
            check("srch_busy", 32'(bus.busy), 32'd1);
            check("srch_cur",  32'(dut.cur),  32'(orbit[i]));
            bus.limit = 4'd15;
            step("srch");
         end
      end
      check("srch_num",   32'(bus.num),       32'd0);
      check("srch_valid", 32'(bus.num_valid), 32'd1);

      // Result stays put while unconsumed; requests during hold are ignored.
      run = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.req   = (i % 2 == 0);
         bus.limit = 4'd15;
         step("hold");
      end
      check("hold_num",   32'(bus.num),       32'd0);
      check("hold_valid", 32'(bus.num_valid), 32'd1);
      bus.num_ready = 1'b1;
      step("hold_ack");
      check("ack_valid", 32'(bus.num_valid), 32'd0);

      // Seed load while free running.
      seed_we = 1'b1; seed = 4'd9;
      step("seed9");
      check("seed9_a", 32'(dut.cur), 32'd9);
      step("seed9");
      check("seed9_b", 32'(dut.cur), 32'd14);
      step("seed9");
      check("seed9_c", 32'(dut.cur), 32'd7);

      // Seed mid-search redirects the search.
      do_reset("rst2");
      bus.req = 1'b1; bus.limit = 4'd2;
      step("mid_req");
      seed_we = 1'b1; seed = 4'd2;
      step("mid_seed");
      check("mid_seed_busy", 32'(bus.busy), 32'd1);
      step("mid_cap");
      check("mid_cap_num",   32'(bus.num),       32'd2);
      check("mid_cap_valid", 32'(bus.num_valid), 32'd1);

      // Seed coinciding with an accept captures the pre-load value.
      do_reset("rst3");
      bus.req = 1'b1; bus.limit = 4'd2;
      step("co_req");
      for (int i = 0; i < 3; i++) step("co_srch");
      seed_we = 1'b1; seed = 4'd7;
      step("co_acc");
      check("co_num", 32'(bus.num), 32'd0);
      check("co_cur", 32'(dut.cur), 32'd7);

      // Full period from reset.
      do_reset("rst4");
      for (int i = 0; i < MOD; i++) seen[i] = 0;
      run = 1'b1;
      for (int i = 0; i < MOD; i++) begin
         step("period");
         seen[int'(dut.cur)]++;
      end
      check("period_end", 32'(dut.cur), 32'd4);
      for (int i = 0; i < MOD; i++) check("period_once", 32'(seen[i]), 32'd1);

      // Reset during search and during hold discards the pending work.
      do_reset("rst5");
      bus.req = 1'b1; bus.limit = 4'd2;
      step("rsrch_req");
      step("rsrch");
      do_reset("rst_srch");
      check("rst_srch_busy", 32'(bus.busy), 32'd0);
      bus.req = 1'b1; bus.limit = 4'd15;
      step("rhold_req");
      do_reset("rst_hold");
      check("rst_hold_valid", 32'(bus.num_valid), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 63) == 0) do_reset("rnd_rst");
         run           = 1'($urandom_range(0, 1));
         bus.req       = ($urandom_range(0, 3) == 0);
         bus.limit     = 4'($urandom_range(0, 15));
         bus.num_ready = ($urandom_range(0, 2) == 0);
         seed_we       = ($urandom_range(0, 15) == 0);
         seed          = 4'($urandom_range(0, 15));
         step("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
